// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of 32-bit unsigned products into a saturating ACC_W-bit accumulator.
// Latency: result valid the cycle after the last product is accepted (the cycle after start when len=0).
// Backpressure: prod_ready only in ACCUM; the result holds in DONE until res_ready, and start is ignored outside IDLE.
module dot_product_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [31:0]      prod_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    // One extra bit catches the carry out that signals saturation.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, prod_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Once saturated the sum stays pinned at all ones until the next start.
                    if (sum[ACC_W] || ovf_q) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res_data   = (state_q == DONE) ? acc_q : '0;
    assign res_ovf    = (state_q == DONE) ? ovf_q : 1'b0;

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream consumer of the 16-bit carry-save multiplier. Accepts a stream of 32-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a saturating accumulator. Presents the final sum on a second valid/ready handshake. Together with the multiplier, it forms the datapath for unsigned dot products.

## Interface
- `ACC_W`, 40, accumulator/result width; must be ≥ 32.
- `CNT_W`, 8, width of the term-count field.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `len`  in  CNT_W  number of products to sum; latched with `start`.
- `prod_valid`  in  1  `prod_data` is valid.
- `prod_ready`  out  1  block accepts a product this cycle.
- `prod_data`  in  32  unsigned product from the multiplier, zero-extended to ACC_W.
- `res_valid`  out  1  `res_data` and `res_ovf` are valid.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  ACC_W  final sum.
- `res_ovf`  out  1  sum saturated during this accumulation.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, ACCUM and DONE. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- IDLE:
  - `prod_ready=0`, `res_valid=0`.
  - `start=1` latches `len` into the remaining-count register and clears the accumulator and the overflow flag.
  - If `len!=0`, go to ACCUM; if `len=0`, go to DONE with a sum of 0.
- ACCUM:
  - `prod_ready=1`.
  - Each edge with `prod_valid & prod_ready` adds `prod_data` and decrements the remaining count.
  - When the accepted term is the last one (remaining==1), go to DONE.
  - Cycles with `prod_valid=0` change nothing.
- DONE:
  - `res_valid=1`; `res_data` = accumulator; `res_ovf` = overflow flag.
  - On an edge with `res_valid & res_ready`, go to IDLE.
  - Outputs hold stable while `res_ready=0`.
- `start` is ignored in ACCUM and DONE, including in the cycle of the result handshake.
- Arithmetic:
  - Compute `acc + zext(prod_data)` in ACC_W+1 bits.
  - If bit ACC_W is set, or the overflow flag is already set, load acc with all ones and set the overflow flag (sticky until the next `start`).
  - Otherwise load the ACC_W-bit sum.
- Defaults cannot overflow: 255·(2³²−1) < 2⁴⁰. Saturation is reachable only with a smaller ACC_W.
- Reset (asynchronous, any state, including mid-accumulation):
  - state=IDLE; acc=0; count=0; ovf flag=0.
  - Outputs: `prod_ready=0`, `res_valid=0`, `res_data=0`, `res_ovf=0`, `busy=0`.
  - A partial sum is discarded and no result is emitted.

## Timing
- Start: `start` sampled at edge t in IDLE → `busy` and `prod_ready` high from t+1 (`len≠0`).
- Product acceptance: at most one product per cycle; back-to-back acceptance at full rate.
- Result latency: last product accepted at edge e → `res_valid=1` during the cycle after e.
- Zero-length case: with `len=0`, `res_valid=1` in the cycle after the `start` edge.
- Return to IDLE: result handshake at edge h → IDLE from h+1. The earliest accepted next `start` is at edge h+1.
- Minimum operation time: an N-term operation with no stalls takes N+2 cycles from `start` to IDLE.
- `res_data`/`res_ovf` are unchanged from entry to DONE until the handshake.

## Test plan
- **Reset:** assert `rst_n=0` asynchronously mid-cycle → `prod_ready`, `res_valid`, `res_data`, `res_ovf`, `busy` all 0 immediately. They stay 0 after release with `start=0`.
- **Basic sum:** `start` with `len=3`; products 3, 5, 7 (A=1·B=3, 5, 7) streamed back-to-back → `res_valid` in the cycle after the 3rd acceptance, `res_data=15`, `res_ovf=0`.
- **Back-pressure:**
  - Stimulus: `len=4`, products 0x0001_0000, 2, 0xFFFF_FFFF, 1, with `prod_valid` gaps of 2 cycles between terms; then hold `res_ready=0` for 5 cycles.
  - Response: `res_data=0x1_0001_0002`, stable through the stall. `busy` drops the cycle after the handshake.
  - Also drive `start` during ACCUM and DONE → ignored.
- **Zero length:** `len=0` → `res_valid=1` the cycle after `start`; `res_data=0`; `prod_ready` never asserted.
- **Saturation (ACC_W=34):** `len=5`, five products of 0xFFFF_FFFF.
  - After 4 terms the sum is 17179869180, with no overflow.
  - After the 5th term → `res_data=0x3_FFFF_FFFF`, `res_ovf=1`.
  - A following `len=1`, product 2 → `res_data=2`, `res_ovf=0`.
- **Reset mid-operation:** `len=4`; accept 100 and 200; pulse `rst_n` low → IDLE, with no `res_valid` ever seen for that operation. Then `len=1`, product 9 → `res_data=9`.
